// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display bus: segment bit positions,
// the 16-entry hex glyph table used by the encoder and decoder, and digit count.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high gfedcba glyphs, element n is the glyph for hex value n.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic       ok;
    logic [3:0] value;
  } seg_decode_t;

  typedef enum logic [1:0] {
    ADDR_BLANK  = 2'd0,
    ADDR_ONEHOT = 2'd1,
    ADDR_MULTI  = 2'd2
  } addr_kind_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    return SEG_PATTERNS[value];
  endfunction

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// Combinational reverse lookup of a 7-bit active-high glyph to its hex value;
// ok is low for any pattern not present in the glyph table.
module seven_seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0]  i_pattern,
  output seg_decode_t o_decode
);

  always_comb begin
    o_decode = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_pattern == SEG_PATTERNS[i[3:0]]) begin
        o_decode.ok    = 1'b1;
        o_decode.value = i[3:0];
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Loopback monitor for the multiplexed display bus: qualifies stable dwells,
// decodes each digit into shadow registers and publishes complete six-digit frames.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter bit          ADDR_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] addr_in,
  input  logic [7:0] seg_in,
  output logic [3:0] data_out5,
  output logic [3:0] data_out4,
  output logic [3:0] data_out3,
  output logic [3:0] data_out2,
  output logic [3:0] data_out1,
  output logic [3:0] data_out0,
  output logic [5:0] dp_out,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       bus_err
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [5:0]                  r_addr;
  logic [7:0]                  r_seg;
  logic [CNT_W-1:0]            r_cnt;
  logic [NUM_DIGITS-1:0][3:0]  r_shadow;
  logic [NUM_DIGITS-1:0]       r_shadow_dp;
  logic [NUM_DIGITS-1:0]       r_seen;
  logic [NUM_DIGITS-1:0][3:0]  r_data;
  logic [NUM_DIGITS-1:0]       r_dp;
  logic                        r_frame_valid;
  logic                        r_seg_err;
  logic                        r_bus_err;

  logic                        w_same;
  logic                        w_qualify;
  logic [5:0]                  w_addr;
  logic [7:0]                  w_seg;
  addr_kind_t                  w_kind;
  seg_decode_t                 w_dec;
  logic                        w_capture;
  logic [NUM_DIGITS-1:0]       w_seen_next;
  logic [NUM_DIGITS-1:0][3:0]  w_shadow_next;
  logic [NUM_DIGITS-1:0]       w_dp_next;

  // The incoming pair is compared with the registered pair, so the counter tracks
  // how many edges the registered pair has already been held unchanged.
  assign w_same    = (addr_in == r_addr) && (seg_in == r_seg);
  assign w_qualify = w_same && (r_cnt == CNT_W'(STABLE_CYCLES - 2));

  assign w_addr = ADDR_ACTIVE_LOW ? ~r_addr : r_addr;
  assign w_seg  = SEG_ACTIVE_LOW  ? ~r_seg  : r_seg;

  always_comb begin
    w_kind = ADDR_ONEHOT;
    if (w_addr == '0)
      w_kind = ADDR_BLANK;
    else if ((w_addr & (w_addr - 6'd1)) != '0)
      w_kind = ADDR_MULTI;
  end

  seven_seg_pattern_decoder u_pattern_decoder (
    .i_pattern (w_seg[6:0]),
    .o_decode  (w_dec)
  );

  assign w_capture   = w_qualify && (w_kind == ADDR_ONEHOT) && w_dec.ok;
  assign w_seen_next = r_seen | w_addr;

  always_comb begin
    w_shadow_next = r_shadow;
    w_dp_next     = r_shadow_dp;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_addr[i]) begin
        w_shadow_next[i] = w_dec.value;
        w_dp_next[i]     = w_seg[SEG_DP];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr        <= '0;
      r_seg         <= '0;
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_shadow_dp   <= '0;
      r_seen        <= '0;
      r_data        <= '0;
      r_dp          <= '0;
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      r_addr <= addr_in;
      r_seg  <= seg_in;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CNT_W'(STABLE_CYCLES))
        r_cnt <= r_cnt + 1'b1;

      r_frame_valid <= 1'b0;
      r_seg_err     <= w_qualify && (w_kind == ADDR_ONEHOT) && !w_dec.ok;
      r_bus_err     <= w_qualify && (w_kind == ADDR_MULTI);

      if (w_capture) begin
        r_shadow    <= w_shadow_next;
        r_shadow_dp <= w_dp_next;
        if (w_seen_next == '1) begin
          r_data        <= w_shadow_next;
          r_dp          <= w_dp_next;
          r_frame_valid <= 1'b1;
          r_seen        <= '0;
        end else begin
          r_seen <= w_seen_next;
        end
      end
    end
  end

  assign data_out5   = r_data[5];
  assign data_out4   = r_data[4];
  assign data_out3   = r_data[3];
  assign data_out2   = r_data[2];
  assign data_out1   = r_data[1];
  assign data_out0   = r_data[0];
  assign dp_out      = r_dp;
  assign frame_valid = r_frame_valid;
  assign seg_err     = r_seg_err;
  assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: each driven dwell is run through a dwell-level reference model
// that queues expected events; a negedge monitor pops and compares DUT events.
module tb_seven_seg_scan_decoder;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] addr_in;
  logic [7:0] seg_in;
  logic [3:0] data_out5, data_out4, data_out3, data_out2, data_out1, data_out0;
  logic [5:0] dp_out;
  logic       frame_valid, seg_err, bus_err;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(
    .STABLE_CYCLES   (S),
    .ADDR_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr_in     (addr_in),
    .seg_in      (seg_in),
    .data_out5   (data_out5),
    .data_out4   (data_out4),
    .data_out3   (data_out3),
    .data_out2   (data_out2),
    .data_out1   (data_out1),
    .data_out0   (data_out0),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .bus_err     (bus_err)
  );

  // Event code is {bus_err, seg_err, frame_valid}.
  typedef struct packed {
    logic [2:0]  code;
    logic [23:0] data;
    logic [5:0]  dp;
  } ev_t;

  ev_t         q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_frames = 0;

  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [3:0]  m_val [6];
  logic [5:0]  m_dpv;
  logic [5:0]  m_seen;
  logic [23:0] m_out;
  logic [5:0]  m_out_dp;

  wire [23:0] w_out = {data_out5, data_out4, data_out3, data_out2, data_out1, data_out0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) m_val[i] = 4'd0;
    m_dpv = '0; m_seen = '0; m_out = '0; m_out_dp = '0;
  endtask

  // Dwell-level model: a dwell of len cycles with active-high addr a and segments s.
  task automatic model_dwell(input logic [5:0] a, input logic [7:0] s, input int unsigned len);
    ev_t e;
    int  found;
    int  n;
    if (len < S || a == 6'd0) return;
    e = '0;
    if ($countones(a) > 1) begin
      e.code = 3'b100;
      q.push_back(e);
      return;
    end
    n = $clog2(a);
    found = -1;
    for (int v = 0; v < 16; v++) if (glyph[v] == s[6:0]) found = v;
    if (found < 0) begin
      e.code = 3'b010;
      q.push_back(e);
      return;
    end
    m_val[n] = 4'(found);
    m_dpv[n] = s[7];
    m_seen[n] = 1'b1;
    if (m_seen == 6'h3F) begin
      m_seen = '0;
      m_out = {m_val[5], m_val[4], m_val[3], m_val[2], m_val[1], m_val[0]};
      m_out_dp = m_dpv;
      e.code = 3'b001;
      e.data = m_out;
      e.dp   = m_out_dp;
      q.push_back(e);
    end
  endtask

  // Entered and left at posedge+1; a one-cycle blank separates successive dwells.
  task automatic dwell(input logic [5:0] a, input logic [7:0] s, input int unsigned len);
    model_dwell(a, s, len);
    addr_in = ~a;
    seg_in  = ~s;
    repeat (len) @(posedge clk);
    #1;
    addr_in = 6'h3F;
    seg_in  = 8'hFF;
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input int n, input logic [3:0] v, input int unsigned len);
    dwell(6'(1 << n), {1'b0, glyph[v]}, len);
  endtask

  task automatic do_reset();
    chk("queue_drained_before_reset", q.size(), 0);
    addr_in = 6'h3F;
    seg_in  = 8'hFF;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    chk("reset_data", w_out, 24'h0);
    chk("reset_dp", dp_out, 6'h0);
    chk("reset_pulses", {bus_err, seg_err, frame_valid}, 3'b000);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if ({bus_err, seg_err, frame_valid} != 3'b000) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got code %b expected none", {bus_err, seg_err, frame_valid});
      end else begin
        e = q.pop_front();
        chk("event_code", {bus_err, seg_err, frame_valid}, e.code);
        if (e.code == 3'b001) begin
          n_frames++;
          chk("frame_data", w_out, e.data);
          chk("frame_dp", dp_out, e.dp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned fr;
    logic [3:0]  bcd [6];
    logic [5:0]  a;
    logic [7:0]  s;

    model_clear();
    addr_in = 6'h3F;
    seg_in  = 8'hFF;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // 1: digits 5..0 = 1..6
    for (int n = 5; n >= 0; n--) digit(n, 4'(6 - n), 10);
    chk("t1_frames", n_frames, 1);
    chk("t1_data", w_out, 24'h123456);
    chk("t1_dp", dp_out, 6'h00);

    // 2: short dwell on digit 2 with an 8 glyph is ignored
    digit(5, 4'd7, 6); digit(4, 4'd8, 6); digit(3, 4'd9, 6); digit(2, 4'd4, 6);
    dwell(6'b000100, 8'h7F, S - 1);
    digit(1, 4'hA, 6); digit(0, 4'hB, 6);
    chk("t2_frames", n_frames, 2);
    chk("t2_data", w_out, 24'h7894AB);

    // 3: blank glyph on digit 3 -> seg_err, frame waits for a valid digit 3
    fr = n_frames;
    digit(5, 4'd1, 8); digit(4, 4'd1, 8);
    dwell(6'b001000, 8'h00, 10);
    digit(2, 4'd2, 8); digit(1, 4'd3, 8); digit(0, 4'd4, 8);
    chk("t3_no_frame", n_frames, fr);
    chk("t3_hold", w_out, 24'h7894AB);
    digit(3, 4'hC, 8);
    chk("t3_frame", n_frames, fr + 1);
    chk("t3_data", w_out, 24'h11C234);

    // 4: two-hot select -> bus_err, seen mask untouched
    fr = n_frames;
    for (int n = 5; n >= 1; n--) digit(n, 4'(n + 9), 7);
    dwell(~6'b110011, {1'b0, glyph[8]}, 10);
    digit(0, 4'hF, 7);
    chk("t4_frame", n_frames, fr + 1);
    chk("t4_data", w_out, 24'hEDCBAF);

    // 5: reset mid-frame forgets captured digits
    for (int n = 0; n <= 3; n++) digit(n, 4'(n + 1), 8);
    do_reset();
    fr = n_frames;
    digit(4, 4'd5, 8); digit(5, 4'd6, 8);
    chk("t5_no_frame", n_frames, fr);
    chk("t5_data_zero", w_out, 24'h0);
    chk("t5_dp_zero", dp_out, 6'h0);

    // 6: emulated display scan of random BCD values
    for (int it = 0; it < 10; it++) begin
      for (int n = 0; n < 6; n++) bcd[n] = 4'($urandom_range(0, 9));
      fr = n_frames;
      for (int n = 5; n >= 0; n--) digit(n, bcd[n], $urandom_range(S, 12));
      chk("t6_frame", n_frames, fr + 1);
      chk("t6_data", w_out, {bcd[5], bcd[4], bcd[3], bcd[2], bcd[1], bcd[0]});
      chk("t6_dp", dp_out, 6'h0);
    end

    // Random mix: short dwells, bad glyphs, multi-hot selects, dp bits
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 99) < 80) a = 6'(1 << $urandom_range(0, 5));
      else begin
        a = 6'($urandom_range(1, 63));
        if ($countones(a) < 2) a = a | 6'b100001;
      end
      if ($urandom_range(0, 99) < 80) s = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
      else s = 8'($urandom_range(0, 255));
      dwell(a, s, $urandom_range(2, 10));
    end

    repeat (10) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    chk("final_hold_data", w_out, m_out);
    chk("final_hold_dp", dp_out, m_out_dp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
